// File: rtl/sym9_frame_feeder.sv
// Serial-to-9-bit frame assembler for the 3..6-of-9 symmetric block. It waits LAT cycles,
// captures y0, hands the result off on valid/ready, and keeps a saturating count of wrong y0 values.
module sym9_frame_feeder #(
  parameter int LAT    = 1,
  parameter int CHK_LO = 3,
  parameter int CHK_HI = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_data,
  input  logic       s_flush,
  output logic [8:0] sym_x,
  input  logic       sym_y,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_data,
  output logic [3:0] m_count,
  output logic       m_mismatch,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] LAT_W = 4'(LAT);
  localparam logic [3:0] LO_W  = 4'(CHK_LO);
  localparam logic [3:0] HI_W  = 4'(CHK_HI);

  typedef enum logic [1:0] {COLLECT, WAIT, HOLD} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [8:0] r_asm;
  logic [3:0] r_wait;
  logic [8:0] r_sym_x;
  logic       r_m_valid;
  logic       r_m_data;
  logic [3:0] r_m_count;
  logic       r_m_mm;
  logic [7:0] r_err;
  logic       w_s_ready;
  logic       w_wait_done;
  logic       w_handshake;
  logic [8:0] w_word;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < 9; i++) acc = acc + {3'd0, v[i]};
    return acc;
  endfunction

  function automatic logic in_range(input logic [3:0] c);
    return (c >= LO_W) && (c <= HI_W);
  endfunction

  assign w_word = {s_data, r_asm[7:0]};

  always_comb begin
    w_next      = r_state;
    w_s_ready   = 1'b0;
    w_wait_done = 1'b0;
    w_handshake = 1'b0;
    unique case (r_state)
      COLLECT: begin
        w_s_ready = 1'b1;
        if (s_valid && !s_flush && r_cnt == 4'd8) w_next = WAIT;
      end
      WAIT: begin
        w_wait_done = (r_wait == 4'd1);
        if (w_wait_done) w_next = HOLD;
      end
      HOLD: begin
        w_handshake = m_ready;
        if (m_ready) w_next = COLLECT;
      end
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_cnt     <= 4'd0;
      r_asm     <= 9'd0;
      r_wait    <= 4'd0;
      r_sym_x   <= 9'd0;
      r_m_valid <= 1'b0;
      r_m_data  <= 1'b0;
      r_m_count <= 4'd0;
      r_m_mm    <= 1'b0;
      r_err     <= 8'd0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        COLLECT: begin
          // Flush takes priority over a bit offered on the same edge.
          if (s_flush) begin
            r_cnt <= 4'd0;
            r_asm <= 9'd0;
          end else if (s_valid) begin
            if (r_cnt == 4'd8) begin
              r_sym_x   <= w_word;
              r_m_count <= popcount9(w_word);
              r_cnt     <= 4'd0;
              r_asm     <= 9'd0;
              r_wait    <= LAT_W;
            end else begin
              r_asm[r_cnt] <= s_data;
              r_cnt        <= r_cnt + 4'd1;
            end
          end
        end
        WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (w_wait_done) begin
            r_m_data  <= sym_y;
            r_m_mm    <= sym_y != in_range(r_m_count);
            r_m_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_handshake) begin
            r_m_valid <= 1'b0;
            if (r_m_mm && r_err != 8'hFF) r_err <= r_err + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready    = w_s_ready;
  assign sym_x      = r_sym_x;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_count    = r_m_count;
  assign m_mismatch = r_m_mm;
  assign err_cnt    = r_err;

endmodule

// File: tb/tb_sym9_frame_feeder.sv
// Randomized bench for sym9_frame_feeder: one instance with LAT=1 and one with LAT=4, each checked
// against a frame-level model (popcount, expected y0, mismatch, saturating error count).
module tb_sym9_frame_feeder;

  logic       clk = 1'b0;
  logic [1:0] rst_n, s_valid, s_data, s_flush, m_ready, sym_y, inv, force0;
  logic [1:0] s_ready, m_valid, m_data, m_mismatch;
  logic [8:0] sym_x   [2];
  logic [3:0] m_count [2];
  logic [7:0] err_cnt [2];

  int n_chk = 0;
  int n_err = 0;
  int mdl_err [2];
  int lat_of  [2];

  always #5 clk = ~clk;

  sym9_frame_feeder #(.LAT(1), .CHK_LO(3), .CHK_HI(6)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_flush(s_flush[0]), .sym_x(sym_x[0]), .sym_y(sym_y[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_count(m_count[0]),
    .m_mismatch(m_mismatch[0]), .err_cnt(err_cnt[0])
  );

  sym9_frame_feeder #(.LAT(4), .CHK_LO(3), .CHK_HI(6)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_flush(s_flush[1]), .sym_x(sym_x[1]), .sym_y(sym_y[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_count(m_count[1]),
    .m_mismatch(m_mismatch[1]), .err_cnt(err_cnt[1])
  );

  // Stand-in for the symmetric block: 1 when 3..6 inputs are set, optionally corrupted.
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      sym_y[u] = 1'b0;
      if (!force0[u])
        sym_y[u] = (($countones(sym_x[u]) >= 3) && ($countones(sym_x[u]) <= 6)) ^ inv[u];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send_bit(input int u, input logic b);
    int c;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    s_valid[u] = 1'b1;
    s_data[u]  = b;
    c = 0;
    while (!s_ready[u] && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (c >= 40) chk("s_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid[u] = 1'b0;
  endtask

  task automatic send_frame(input int u, input logic [8:0] w, input int stall);
    int  c, cnt;
    logic ideal, y, mm;
    cnt   = $countones(w);
    ideal = (cnt >= 3) && (cnt <= 6);
    y     = force0[u] ? 1'b0 : (ideal ^ inv[u]);
    mm    = (y != ideal);
    for (int i = 0; i < 9; i++) send_bit(u, w[i]);
    chk("sym_x", 32'(sym_x[u]), 32'(w));
    chk("s_ready_wait", 32'(s_ready[u]), 32'd0);
    c = 0;
    while (!m_valid[u] && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), 32'(lat_of[u]));
    chk("m_data", 32'(m_data[u]), 32'(y));
    chk("m_count", 32'(m_count[u]), 32'(cnt));
    chk("m_mismatch", 32'(m_mismatch[u]), 32'(mm));
    for (int k = 0; k < stall; k++) begin
      s_valid[u] = 1'b1;
      s_data[u]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_valid", 32'(m_valid[u]), 32'd1);
      chk("hold_data", 32'(m_data[u]), 32'(y));
      chk("hold_count", 32'(m_count[u]), 32'(cnt));
      chk("hold_s_ready", 32'(s_ready[u]), 32'd0);
    end
    s_valid[u] = 1'b0;
    m_ready[u] = 1'b1;
    @(negedge clk);
    m_ready[u] = 1'b0;
    if (mm && mdl_err[u] < 255) mdl_err[u]++;
    chk("post_valid", 32'(m_valid[u]), 32'd0);
    chk("err_cnt", 32'(err_cnt[u]), 32'(mdl_err[u]));
    chk("post_sym_x", 32'(sym_x[u]), 32'(w));
  endtask

  task automatic flush_test(input int u, input logic [8:0] w);
    int k;
    k = $urandom_range(1, 8);
    for (int i = 0; i < k; i++) send_bit(u, 1'($urandom_range(0, 1)));
    s_flush[u] = 1'b1;
    s_valid[u] = 1'b1;
    s_data[u]  = 1'b1;
    @(negedge clk);
    s_flush[u] = 1'b0;
    s_valid[u] = 1'b0;
    send_frame(u, w, 0);
  endtask

  task automatic reset_checks(input int u, input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid[u]), 32'd0);
    chk({tag, "_sym_x"}, 32'(sym_x[u]), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data[u]), 32'd0);
    chk({tag, "_m_count"}, 32'(m_count[u]), 32'd0);
    chk({tag, "_m_mismatch"}, 32'(m_mismatch[u]), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt[u]), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready[u]), 32'd1);
  endtask

  initial begin
    lat_of[0] = 1;
    lat_of[1] = 4;
    mdl_err[0] = 0;
    mdl_err[1] = 0;
    rst_n   = 2'b00;
    s_valid = 2'b00;
    s_data  = 2'b00;
    s_flush = 2'b00;
    m_ready = 2'b00;
    inv     = 2'b00;
    force0  = 2'b00;
    repeat (3) @(negedge clk);
    reset_checks(0, "rst0");
    reset_checks(1, "rst1");
    rst_n = 2'b11;

    send_frame(0, 9'h007, 0);
    send_frame(0, 9'h1FF, 0);
    send_frame(0, 9'h03F, 0);
    send_frame(0, 9'(($urandom)), 5);

    flush_test(0, 9'h1F0);

    force0[0] = 1'b1;
    send_frame(0, 9'h00F, 0);
    force0[0] = 1'b0;

    for (int f = 0; f < 40; f++) begin
      inv[0] = ($urandom_range(0, 3) == 0);
      send_frame(0, 9'($urandom), $urandom_range(0, 3));
    end
    inv[0] = 1'b0;
    for (int f = 0; f < 3; f++) flush_test(0, 9'($urandom));

    force0[0] = 1'b1;
    for (int f = 0; f < 300; f++) send_frame(0, 9'h00F, 0);
    force0[0] = 1'b0;
    send_frame(0, 9'h0F0, 0);

    for (int f = 0; f < 6; f++) begin
      inv[1] = ($urandom_range(0, 1) == 0);
      send_frame(1, 9'($urandom), $urandom_range(0, 2));
    end
    inv[1] = 1'b1;
    send_frame(1, 9'h00F, 0);
    inv[1] = 1'b0;
    for (int i = 0; i < 9; i++) send_bit(1, 1'($urandom_range(0, 1)));
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    mdl_err[1] = 0;
    reset_checks(1, "midwait");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(m_valid[1]), 32'd0);
    end
    rst_n[1] = 1'b1;
    send_frame(1, 9'h1F0, 0);
    for (int f = 0; f < 4; f++) send_frame(1, 9'($urandom), $urandom_range(0, 2));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
